// File: rtl/keypad_scan.sv
// -----------------------------------------------------------------------------
// keypad_scan
//
// Scans a 4x4 matrix keypad one row at a time, debounces the column pattern
// and emits one 4-bit key code per physical press with a single-cycle strobe.
// Consumed by the calculator control FSM for operand digit entry.
//
// Parameters
//   SCAN_DIV      clk cycles each row is driven before its columns are sampled (>=2)
//   DEBOUNCE_CNT  consecutive stable samples needed to accept press/release (>=1)
//   REPEAT_CNT    hold cycles between auto-repeat strobes (auto-repeat build only)
//
// Ports
//   clk      in   system clock
//   rst_n    in   asynchronous active-low reset
//   col_in   in   [3:0] keypad columns, active-low, asynchronous
//   row_out  out  [3:0] row drive, active-low, exactly one bit low
//   key      out  [3:0] code of the last accepted key, held until the next one
//   pressed  out  one-cycle strobe, key valid in the same cycle
//
// Build option
//   KEYPAD_AUTOREPEAT_EN  when defined, a held key re-strobes every REPEAT_CNT
//                         cycles; when undefined exactly one strobe per press.
// -----------------------------------------------------------------------------
module keypad_scan #(
   parameter int unsigned SCAN_DIV     = 50000,
   parameter int unsigned DEBOUNCE_CNT = 20,
   parameter int unsigned REPEAT_CNT   = 25000000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] col_in,
   output logic [3:0] row_out,
   output logic [3:0] key,
   output logic       pressed
);

   localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int unsigned CNT_W = $clog2(DEBOUNCE_CNT + 1);

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CNT - 1);

   typedef enum logic [1:0] {
      S_SCAN     = 2'd0,
      S_DEBOUNCE = 2'd1,
      S_HOLD     = 2'd2
   } state_t;

   // ---------------------------------------------------------------------------
   // Column synchroniser
   // ---------------------------------------------------------------------------
   logic [3:0] col_meta_q;
   logic [3:0] col_s_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         col_meta_q <= 4'hF;
         col_s_q    <= 4'hF;
      end else begin
         col_meta_q <= col_in;
         col_s_q    <= col_meta_q;
      end
   end

   // ---------------------------------------------------------------------------
   // Key decode
   // ---------------------------------------------------------------------------
   function automatic logic [3:0] key_map(input logic [1:0] row, input logic [3:0] pat);
      logic [1:0] col;
      logic [3:0] code;
      col  = 2'd0;
      code = 4'h0;
      unique case (pat)
         4'b1110: col = 2'd0;
         4'b1101: col = 2'd1;
         4'b1011: col = 2'd2;
         4'b0111: col = 2'd3;
         default: col = 2'd0;
      endcase
      case ({row, col})
         4'h0: code = 4'h1;
         4'h1: code = 4'h2;
         4'h2: code = 4'h3;
         4'h3: code = 4'hA;
         4'h4: code = 4'h4;
         4'h5: code = 4'h5;
         4'h6: code = 4'h6;
         4'h7: code = 4'hB;
         4'h8: code = 4'h7;
         4'h9: code = 4'h8;
         4'hA: code = 4'h9;
         4'hB: code = 4'hC;
         4'hC: code = 4'hE;   // '*'
         4'hD: code = 4'h0;
         4'hE: code = 4'hF;   // '#'
         4'hF: code = 4'hD;
         default: code = 4'h0;
      endcase
      return code;
   endfunction

   // ---------------------------------------------------------------------------
   // Scan / debounce / hold FSM
   // ---------------------------------------------------------------------------
   state_t           state_q;
   logic [1:0]       row_q;
   logic [DIV_W-1:0] div_q;
   logic [CNT_W-1:0] cnt_q;
   logic [3:0]       pat_q;
   logic [3:0]       key_q;
   logic             pressed_q;

   logic       col_valid;
   logic       col_idle;
   logic       col_match;
   logic [3:0] key_d;

   // Exactly one low column is a usable press; all-high or multiple lows
   // (ghosting) are both treated as nothing pressed.
   assign col_valid = $onehot(~col_s_q);
   assign col_idle  = (col_s_q == 4'hF);
   assign col_match = (col_s_q == pat_q);
   assign key_d     = key_map(row_q, pat_q);

`ifdef KEYPAD_AUTOREPEAT_EN
   localparam int unsigned REP_W = $clog2(REPEAT_CNT + 1);
   localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CNT - 1);
   logic [REP_W-1:0] rep_q;
`else
   logic [31:0] unused_repeat;
   assign unused_repeat = 32'(REPEAT_CNT);
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_SCAN;
         row_q     <= 2'd0;
         div_q     <= '0;
         cnt_q     <= '0;
         pat_q     <= 4'hF;
         key_q     <= 4'h0;
         pressed_q <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
         rep_q     <= '0;
`endif
      end else begin
         pressed_q <= 1'b0;
         case (state_q)
            S_SCAN: begin
               if (div_q == DIV_LAST) begin
                  div_q <= '0;
                  if (col_valid) begin
                     pat_q   <= col_s_q;
                     cnt_q   <= '0;
                     state_q <= S_DEBOUNCE;
                  end else begin
                     row_q <= row_q + 2'd1;
                  end
               end else begin
                  div_q <= div_q + DIV_W'(1);
               end
            end

            S_DEBOUNCE: begin
               if (!col_match) begin
                  // Bounce: retry the same row from a fresh divider period.
                  div_q   <= '0;
                  state_q <= S_SCAN;
               end else if (cnt_q == CNT_LAST) begin
                  key_q     <= key_d;
                  pressed_q <= 1'b1;
                  cnt_q     <= '0;
                  state_q   <= S_HOLD;
`ifdef KEYPAD_AUTOREPEAT_EN
                  rep_q     <= '0;
`endif
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end

            S_HOLD: begin
               // Release needs DEBOUNCE_CNT consecutive all-high samples.
               if (col_idle) begin
                  if (cnt_q == CNT_LAST) begin
                     cnt_q   <= '0;
                     div_q   <= '0;
                     row_q   <= row_q + 2'd1;
                     state_q <= S_SCAN;
                  end else begin
                     cnt_q <= cnt_q + CNT_W'(1);
                  end
               end else begin
                  cnt_q <= '0;
               end
`ifdef KEYPAD_AUTOREPEAT_EN
               // Repeat timer only advances while the original pattern holds.
               if (col_match) begin
                  if (rep_q == REP_LAST) begin
                     pressed_q <= 1'b1;
                     rep_q     <= '0;
                  end else begin
                     rep_q <= rep_q + REP_W'(1);
                  end
               end else begin
                  rep_q <= '0;
               end
`endif
            end

            default: begin
               state_q <= S_SCAN;
               div_q   <= '0;
               cnt_q   <= '0;
            end
         endcase
      end
   end

   assign row_out = ~(4'b0001 << row_q);
   assign key     = key_q;
   assign pressed = pressed_q;

endmodule

// File: tb/tb_keypad_scan.sv
module tb_keypad_scan;

   localparam int SD      = 4;
   localparam int DB      = 8;
   localparam int RP      = 40;
   localparam int LAT_MIN = 2 + 1 + DB;
   localparam int LAT_MAX = 2 + 4 * SD + DB + 1;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] col_in;
   logic [3:0] row_out;
   logic [3:0] key;
   logic       pressed;

   logic [15:0] keys_dn = '0;   // bit r*4+c = switch at row r / column c closed

   int tests = 0;
   int fails = 0;
   int cyc = 0;
   int strobe_cnt = 0;
   logic [3:0] last_key = 4'h0;
   bit prev_p = 1'b0;
   int strobe_cyc[$];

   keypad_scan #(
      .SCAN_DIV(SD),
      .DEBOUNCE_CNT(DB),
      .REPEAT_CNT(RP)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .col_in(col_in),
      .row_out(row_out),
      .key(key),
      .pressed(pressed)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Physical matrix: a closed switch pulls its column low while its row is driven.
   always_comb begin
      col_in = 4'hF;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (keys_dn[r*4+c] && !row_out[r]) col_in[c] = 1'b0;
   end

   // Strobe monitor.
   always @(negedge clk) begin
      if (rst_n && pressed) begin
         tests++;
         if (prev_p) begin
            fails++;
            $display("FAIL strobe_gap: pressed high on consecutive cycles at cycle %0d, required at least one low cycle between", cyc);
         end
         strobe_cnt++;
         last_key = key;
         strobe_cyc.push_back(cyc);
      end
      prev_p = rst_n && pressed;
   end

   function automatic logic [3:0] ref_code(input int idx);
      logic [3:0] tab [16];
      tab = '{4'h1, 4'h2, 4'h3, 4'hA,
              4'h4, 4'h5, 4'h6, 4'hB,
              4'h7, 4'h8, 4'h9, 4'hC,
              4'hE, 4'h0, 4'hF, 4'hD};
      return tab[idx];
   endfunction

   function automatic logic [3:0] row_pat(input int r);
      logic [3:0] one;
      one = 4'b0001;
      return ~(one << r);
   endfunction

   // Expected strobe count for a single key held 'hold' cycles whose first strobe came 'lat' cycles after closing.
   function automatic int exp_strobes(input int hold, input int lat);
`ifdef KEYPAD_AUTOREPEAT_EN
      return 1 + (hold - lat) / RP;
`else
      return (hold > 0 && lat >= 0) ? 1 : 1;
`endif
   endfunction

   task automatic step(input int n);
      repeat (n) begin
         @(negedge clk);
         #1;
      end
   endtask

   task automatic wait_row_entry(input logic [3:0] tgt, output bit ok);
      int n;
      n = 0;
      while (row_out == tgt && n < 100) begin step(1); n++; end
      while (row_out != tgt && n < 100) begin step(1); n++; end
      ok = (row_out == tgt);
   endtask

   // Close switch idx for 'hold' cycles, then open it; reports first-strobe latency,
   // strobe count, and cycles after the first strobe on which the row was not frozen.
   task automatic press_hold(input int idx, input int hold, output int lat, output int n, output int unfrozen);
      int s0;
      int t0;
      s0 = strobe_cnt;
      unfrozen = 0;
      keys_dn[idx] = 1'b1;
      t0 = cyc;
      while (cyc - t0 < hold) begin
         step(1);
         if (strobe_cnt > s0 && row_out !== row_pat(idx / 4)) unfrozen++;
      end
      keys_dn[idx] = 1'b0;
      n = strobe_cnt - s0;
      lat = (n > 0) ? strobe_cyc[s0] - t0 : -1;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      keys_dn = '0;
      step(3);
      rst_n = 1'b1;
      step(7);
      #1;
      rst_n = 1'b0;
      #1;
      tests++;
      if (row_out !== 4'b1110) begin fails++; $display("FAIL reset_row: got %b expected 1110", row_out); end
      tests++;
      if (key !== 4'h0) begin fails++; $display("FAIL reset_key: got %h expected 0", key); end
      tests++;
      if (pressed !== 1'b0) begin fails++; $display("FAIL reset_pressed: got %b expected 0", pressed); end
      step(2);
      rst_n = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tests++;
         if (row_out !== row_pat((i / SD) % 4)) begin
            fails++;
            $display("FAIL row_walk[%0d]: got %b expected %b", i, row_out, row_pat((i / SD) % 4));
         end
         step(1);
      end
   endtask

   task automatic test_single_key;
      int lat, n, unf, m;
      press_hold(6, 200, lat, n, unf);
      tests++;
      if (lat < LAT_MIN || lat > LAT_MAX) begin fails++; $display("FAIL single_latency: got %0d expected %0d..%0d", lat, LAT_MIN, LAT_MAX); end
      tests++;
      if (n != exp_strobes(200, lat)) begin fails++; $display("FAIL single_count: got %0d expected %0d", n, exp_strobes(200, lat)); end
      tests++;
      if (last_key !== ref_code(6)) begin fails++; $display("FAIL single_key: got %h expected %h", last_key, ref_code(6)); end
      tests++;
      if (unf != 0) begin fails++; $display("FAIL single_frozen: row moved on %0d cycles expected 0", unf); end
      m = 0;
      while (row_out === 4'b1101 && m < 50) begin step(1); m++; end
      tests++;
      if (m != 2 + DB) begin fails++; $display("FAIL release_time: got %0d expected %0d", m, 2 + DB); end
      tests++;
      if (row_out !== 4'b1011) begin fails++; $display("FAIL release_row: got %b expected 1011", row_out); end
      step(10);
   endtask

   task automatic test_bounce;
      bit ok;
      int s0, lat, n, unf;
      s0 = strobe_cnt;
      wait_row_entry(4'b0111, ok);
      tests++;
      if (!ok) begin fails++; $display("FAIL bounce_row_wait: row 0111 not reached, got %b", row_out); end
      keys_dn[13] = 1'b1;
      step(5);
      keys_dn[13] = 1'b0;
      step(40);
      tests++;
      if (strobe_cnt != s0) begin fails++; $display("FAIL bounce_strobe: got %0d strobes expected 0", strobe_cnt - s0); end
      press_hold(13, 200, lat, n, unf);
      tests++;
      if (n != exp_strobes(200, lat)) begin fails++; $display("FAIL bounce_stable_count: got %0d expected %0d", n, exp_strobes(200, lat)); end
      tests++;
      if (last_key !== ref_code(13)) begin fails++; $display("FAIL bounce_stable_key: got %h expected %h", last_key, ref_code(13)); end
      step(2 + DB + 10);
   endtask

   task automatic test_ghost;
      int s0;
      logic [3:0] seen;
      s0 = strobe_cnt;
      seen = 4'h0;
      keys_dn[0] = 1'b1;
      keys_dn[3] = 1'b1;
      for (int i = 0; i < 200; i++) begin
         step(1);
         for (int r = 0; r < 4; r++) if (row_out === row_pat(r)) seen[r] = 1'b1;
      end
      keys_dn = '0;
      tests++;
      if (strobe_cnt != s0) begin fails++; $display("FAIL ghost_strobe: got %0d strobes expected 0", strobe_cnt - s0); end
      tests++;
      if (seen !== 4'hF) begin fails++; $display("FAIL ghost_scan: rows seen %b expected 1111", seen); end
      step(10);
   endtask

   task automatic test_autorepeat;
      int s0, lat, n, unf;
      s0 = strobe_cnt;
      press_hold(8, 200, lat, n, unf);
      tests++;
      if (n != exp_strobes(200, lat)) begin fails++; $display("FAIL repeat_count: got %0d expected %0d", n, exp_strobes(200, lat)); end
      tests++;
      if (last_key !== ref_code(8)) begin fails++; $display("FAIL repeat_key: got %h expected %h", last_key, ref_code(8)); end
      for (int i = 1; i < n; i++) begin
         tests++;
         if (strobe_cyc[s0+i] - strobe_cyc[s0+i-1] != RP) begin
            fails++;
            $display("FAIL repeat_gap[%0d]: got %0d expected %0d", i, strobe_cyc[s0+i] - strobe_cyc[s0+i-1], RP);
         end
      end
      step(40);
      tests++;
      if (strobe_cnt - s0 != n) begin fails++; $display("FAIL repeat_after_release: got %0d extra strobes expected 0", strobe_cnt - s0 - n); end
   endtask

   task automatic test_reset_in_debounce;
      bit ok;
      int s0;
      wait_row_entry(4'b1101, ok);
      tests++;
      if (!ok) begin fails++; $display("FAIL rstdb_row_wait: row 1101 not reached, got %b", row_out); end
      s0 = strobe_cnt;
      keys_dn[5] = 1'b1;
      step(6);
      #1;
      rst_n = 1'b0;
      #1;
      tests++;
      if (row_out !== 4'b1110) begin fails++; $display("FAIL rstdb_row: got %b expected 1110", row_out); end
      tests++;
      if (key !== 4'h0) begin fails++; $display("FAIL rstdb_key: got %h expected 0", key); end
      tests++;
      if (pressed !== 1'b0) begin fails++; $display("FAIL rstdb_pressed: got %b expected 0", pressed); end
      keys_dn = '0;
      step(3);
      rst_n = 1'b1;
      tests++;
      if (row_out !== 4'b1110) begin fails++; $display("FAIL rstdb_restart_row: got %b expected 1110", row_out); end
      step(SD);
      tests++;
      if (row_out !== 4'b1101) begin fails++; $display("FAIL rstdb_next_row: got %b expected 1101", row_out); end
      step(40);
      tests++;
      if (strobe_cnt != s0) begin fails++; $display("FAIL rstdb_strobe: got %0d strobes expected 0", strobe_cnt - s0); end
      tests++;
      if (key !== 4'h0) begin fails++; $display("FAIL rstdb_key_after: got %h expected 0", key); end
   endtask

   task automatic test_random;
      bit ok;
      int r, c, idx, len, hold, lat, n, unf, s0;
      for (int it = 0; it < 16; it++) begin
         r = int'($urandom_range(0, 3));
         c = int'($urandom_range(0, 3));
         idx = r * 4 + c;
         if ($urandom_range(0, 2) == 0) begin
            s0 = strobe_cnt;
            wait_row_entry(row_pat(r), ok);
            len = int'($urandom_range(1, DB - 2));
            keys_dn[idx] = 1'b1;
            step(len);
            keys_dn[idx] = 1'b0;
            step(30);
            tests++;
            if (!ok || strobe_cnt != s0) begin
               fails++;
               $display("FAIL rand_bounce[%0d]: key %h len %0d got %0d strobes expected 0", it, ref_code(idx), len, strobe_cnt - s0);
            end
         end else begin
            step(int'($urandom_range(0, 7)));
            hold = int'($urandom_range(LAT_MAX + 3, LAT_MIN + RP - 6));
            press_hold(idx, hold, lat, n, unf);
            tests++;
            if (n != 1 || last_key !== ref_code(idx)) begin
               fails++;
               $display("FAIL rand_press[%0d]: got %0d strobes key %h expected 1 strobe key %h", it, n, last_key, ref_code(idx));
            end
            tests++;
            if (lat < LAT_MIN || lat > LAT_MAX) begin
               fails++;
               $display("FAIL rand_latency[%0d]: got %0d expected %0d..%0d", it, lat, LAT_MIN, LAT_MAX);
            end
            step(2 + DB + 6);
         end
      end
   endtask

   initial begin
      test_reset();
      test_single_key();
      test_bounce();
      test_ghost();
      test_autorepeat();
      test_random();
      test_reset_in_debounce();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #400000;
      fails++;
      $display("FAIL watchdog: simulation exceeded time limit");
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/keypad_scan.md
# keypad_scan

Scans a 4x4 matrix keypad, debounces contacts, and emits one key code per physical press as a 4-bit code with a single-cycle `pressed` strobe. It sits between the board keypad pins and the calculator control FSM, which consumes `key`/`pressed` to enter BCD operand digits. Column inputs are asynchronous and are synchronised internally.

## Interface
- `SCAN_DIV`, default 50000: clk cycles each row is driven before its columns are sampled; legal range ≥2.
- `DEBOUNCE_CNT`, default 20: consecutive scan-sample cycles a column pattern must stay stable to be accepted; legal range ≥1.
- `REPEAT_CNT`, default 25000000: hold cycles between auto-repeat strobes; used only with auto-repeat compiled in.
- `clk`  input  1  system clock.
- `rst_n`  input  1  reset, asynchronous, active-low.
- `col_in`  input  4  keypad columns, active-low, externally pulled up, asynchronous.
- `row_out`  output  4  keypad row drive, active-low, exactly one bit low at all times.
- `key`  output  4  code of the last accepted key; held until the next acceptance.
- `pressed`  output  1  one-cycle strobe; `key` is valid in the same cycle.

## Operation
- `col_in` passes through a 2-flop synchroniser to give `col_s`; all logic uses `col_s`.
- Key map (row,col -> code): r0: 1,2,3,A; r1: 4,5,6,B; r2: 7,8,9,C; r3: E(*),0,F(#),D.
- A pattern is valid only if exactly one bit of `col_s` is 0. All-ones means idle. Two or more zeros count as ghosting and are treated as idle.
- **SCAN**:
  - Drive `row_out = ~(1<<row)`. The divider counts 0..SCAN_DIV-1.
  - At terminal count, sample `col_s`. A valid pattern latches `col_s` into `pat` and moves to DEBOUNCE with cnt=0. Otherwise `row` advances (3 wraps to 0) and the divider restarts.
- **DEBOUNCE**:
  - Row stays frozen.
  - Each cycle `col_s==pat`: cnt++.
  - Any mismatch: return to SCAN on the same row, divider cleared.
  - When cnt reaches DEBOUNCE_CNT-1 with a match: register `key`=map(row,pat) and `pressed`=1 for the next cycle, then go to HOLD.
- **HOLD**:
  - Row frozen. Wait for `col_s` all-ones for DEBOUNCE_CNT consecutive cycles; any zero resets that counter.
  - Then go to SCAN with `row` advanced by one.
  - A second key pressed while in HOLD is never reported.
- `pressed` never asserts in two consecutive cycles.
- Reset mid-operation: all state returns to reset values immediately. A press in progress is discarded and no strobe is emitted.

## Timing
- Reset values: `row_out`=4'b1110, `key`=4'h0, `pressed`=0, state SCAN, row 0, all counters 0.
- `pressed` and `key` are registered outputs.
- Latency from a stable `col_in` edge to `pressed`:
  - at most 2 (sync) + 4·SCAN_DIV + DEBOUNCE_CNT + 1 cycles;
  - at least 2 + 1 + DEBOUNCE_CNT cycles when the row is already being sampled.
- Release is recognised DEBOUNCE_CNT cycles after `col_s` returns to all-ones.
- A bounce shorter than DEBOUNCE_CNT cycles produces no strobe.

## Configuration
- `KEYPAD_AUTOREPEAT_EN` defined:
  - In HOLD, a repeat counter runs while the same `pat` is held.
  - Every REPEAT_CNT cycles it emits another one-cycle `pressed` with an unchanged `key`.
  - The counter clears on any mismatch.
- Not defined: HOLD emits nothing. Exactly one strobe is produced per press, and the repeat counter is not synthesised.

## Test plan
Bench parameters: SCAN_DIV=4, DEBOUNCE_CNT=8, REPEAT_CNT=40.
- Reset: assert `rst_n`=0 mid-scan -> `row_out`=1110, `key`=0, `pressed`=0 immediately. After release, the row walks 1110→1101→1011→0111→1110 every 4 cycles.
- Hold row1/col2 closed for 200 cycles -> exactly one `pressed` pulse with `key`=4'h6. Row freezes at 1101 until release, plus 8 idle cycles, then advances to 1011.
- Row3/col1 closed with a 5-cycle bounce, then stable -> the bounce produces no strobe; the stable period yields one strobe with `key`=4'h0.
- Row0 col0 and col3 closed together for 200 cycles -> no `pressed`, and scanning continues.
- Hold row2/col0 for 200 cycles:
  - without the macro -> one strobe with `key`=7;
  - with `KEYPAD_AUTOREPEAT_EN` -> a first strobe, then one more every 40 cycles, all with `key`=7.
- Assert reset 3 cycles into DEBOUNCE for key '5' -> no strobe, `key` stays 0, scanning restarts at row 0.
